hazard_tracker: RTL

Decode-stage data-hazard tracker for the pipelined core. Records the destination register of each in-flight writing instruction in EX and MEM and compares decode's source registers against them. Drives the pipeline stall (bubble insertion) and, when forwarding is compiled in, the registered forwarding selects that accompany the instruction into EX. It sits between the decode stage and the ID/EX pipeline register and consumes the same 5-bit register-match function used elsewhere in the datapath.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/dest_match.sv | 19 +
 rtl/hazard_tracker.sv | 102 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the decode-stage hazard tracker.
//   REG_W        register identifier width (32 registers, R0 hardwired zero)
//   FWD_*        EX operand source selects
//   entry_t      tracked in-flight writer {valid, rd, load}
//   fwd_select   forwarding priority helper, youngest producer first
package hazard_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             load;
  } entry_t;

  // A load in EX never reaches here as a forward source: that case stalls.
  function automatic logic [1:0] fwd_select(input logic ex_hit,
                                            input logic ex_load,
                                            input logic mem_hit);
    if (ex_hit && !ex_load) return FWD_MEM;
    else if (mem_hit)       return FWD_WB;
    else                    return FWD_RF;
  endfunction

endpackage

// File: rtl/dest_match.sv
// dest_match: register dependence comparator.
//   valid  in  producer entry is valid
//   used   in  consumer actually reads this source
//   src    in  consumer source register
//   dst    in  producer destination register
//   hit    out 1 on an enabled, nonzero, equal match (R0 never matches)
module dest_match
  import hazard_pkg::*;
(
  input  logic             valid,
  input  logic             used,
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] dst,
  output logic             hit
);

  assign hit = valid & used & (src != '0) & (src == dst);

endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: decode-stage data-hazard tracker.
// Tracks the destination of the writers in EX and MEM, compares decode's
// sources against them, drives the combinational stall and (when built with
// FORWARD_EN) the registered EX forwarding selects.
//   clk, rst               clock, synchronous active-high reset
//   hold                   global freeze; all tracker state holds
//   flush                  squash decode instruction (never recorded)
//   id_valid               decode holds a real instruction
//   id_rs/id_rs_used       source A and its read enable
//   id_rt/id_rt_used       source B and its read enable
//   id_rd/id_wr            destination and its write enable
//   id_is_load             instruction is a load
//   stall                  combinational: hold PC/IF-ID, bubble into ID/EX
//   fwd_a, fwd_b           registered EX operand source selects
// Build option: define FORWARD_EN for forwarding mode (load-use stall only,
// live fwd_a/fwd_b). Undefined: full interlock, fwd_a/fwd_b tied to FWD_RF.
module hazard_tracker
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             id_is_load,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  entry_t ent_p0;   // decode candidate
  entry_t ent_p1;   // instruction in EX
  entry_t ent_p2;   // instruction in MEM

  logic rs_ex, rs_mem, rt_ex, rt_mem;
  logic hazard, advance;

  dest_match u_rs_ex  (.valid(ent_p1.valid), .used(id_rs_used), .src(id_rs), .dst(ent_p1.rd), .hit(rs_ex));
  dest_match u_rs_mem (.valid(ent_p2.valid), .used(id_rs_used), .src(id_rs), .dst(ent_p2.rd), .hit(rs_mem));
  dest_match u_rt_ex  (.valid(ent_p1.valid), .used(id_rt_used), .src(id_rt), .dst(ent_p1.rd), .hit(rt_ex));
  dest_match u_rt_mem (.valid(ent_p2.valid), .used(id_rt_used), .src(id_rt), .dst(ent_p2.rd), .hit(rt_mem));

`ifdef FORWARD_EN
  assign hazard = (rs_ex | rt_ex) & ent_p1.load;
`else
  assign hazard = rs_ex | rs_mem | rt_ex | rt_mem;
`endif

  // flush dominates: the killed instruction never stalls the pipe
  assign stall   = id_valid & ~flush & hazard;
  assign advance = id_valid & ~stall & ~flush;

  assign ent_p0.valid = advance & id_wr & (id_rd != '0);
  assign ent_p0.rd    = id_rd;
  assign ent_p0.load  = id_is_load;

  // ---- ID -> EX -> MEM boundary ----
  // Only the valid bits are reset; rd/load are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_p1.valid <= 1'b0;
      ent_p2.valid <= 1'b0;
    end else if (!hold) begin
      ent_p1 <= ent_p0;
      ent_p2 <= ent_p1;
    end
  end

`ifdef FORWARD_EN
  logic [1:0] fwd_a_p0, fwd_b_p0;

  assign fwd_a_p0 = advance ? fwd_select(rs_ex, ent_p1.load, rs_mem) : FWD_RF;
  assign fwd_b_p0 = advance ? fwd_select(rt_ex, ent_p1.load, rt_mem) : FWD_RF;

  // ---- ID -> EX boundary (forwarding selects) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (!hold) begin
      fwd_a <= fwd_a_p0;
      fwd_b <= fwd_b_p0;
    end
  end

  logic unused_load;
  assign unused_load = ent_p2.load;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;

  logic unused_load;
  assign unused_load = ent_p1.load ^ ent_p2.load;
`endif

endmodule
